instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_pkg.sv | 43 ++++
 rtl/instr_sequencer_prog_mem.sv | 25 ++
 rtl/instr_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared encodings, states and field positions for instr_sequencer
package instr_pkg;

    // Instruction class encodings in bits [31:28]; anything above CLS_HALT is illegal
    localparam logic [3:0] CLS_ALU   = 4'd0;
    localparam logic [3:0] CLS_LOADI = 4'd1;
    localparam logic [3:0] CLS_BRZ   = 4'd2;
    localparam logic [3:0] CLS_HALT  = 4'd3;

    // ALU operation used to test a register for zero (x | x == 0 iff x == 0)
    localparam logic [3:0] OP_OR = 4'd3;

    // Field positions
    localparam int CLS_HI   = 31;
    localparam int CLS_LO   = 28;
    localparam int OPC_HI   = 27;
    localparam int OPC_LO   = 24;
    localparam int DST_HI   = 23;
    localparam int DST_LO   = 19;
    localparam int SRC1_HI  = 18;
    localparam int SRC1_LO  = 14;
    localparam int SRC2_HI  = 13;
    localparam int SRC2_LO  = 9;
    localparam int SHAMT_HI = 8;
    localparam int SHAMT_LO = 4;
    localparam int IMM_HI   = 18;
    localparam int IMM_LO   = 0;
    localparam int TGT_HI   = 3;
    localparam int TGT_LO   = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } seqState_e;

    function automatic logic [31:0] signExtImm(input logic [18:0] imm);
        return {{13{imm[18]}}, imm};
    endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// rtl/instr_sequencer_prog_mem.sv - program store with synchronous write and combinational read
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [31:0]   wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [31:0]   rdData
);

    logic [31:0] mem [DEPTH];

    // Program image survives sequencer reset, so the array has no reset branch
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute/writeback sequencer driving a regfile/ALU datapath
module instr_sequencer
    import instr_pkg::*;
#(
    parameter  int PROG_DEPTH = 16,
    localparam int AW = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               start,
    input  logic               progWrEn,
    input  logic [AW-1:0]      progAddr,
    input  logic [31:0]        progData,
    input  logic signed [31:0] aluResult,
    output logic               wrEnable,
    output logic [4:0]         wrReg,
    output logic [4:0]         rdReg1,
    output logic [4:0]         rdReg2,
    output logic [3:0]         opCode,
    output logic [4:0]         shiftAmt,
    output logic               selCh,
    output logic [31:0]        selData,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [AW-1:0]      pc
);

    seqState_e     state;
    seqState_e     stateNext;
    logic [AW-1:0] pcNext;
    logic [31:0]   ir;
    logic [31:0]   irNext;
    logic          illegalNext;
    logic [31:0]   fetchWord;
    logic          memWrEn;

    logic [3:0]    fetchClass;
    logic [3:0]    irClass;
    logic [3:0]    irOpc;
    logic [4:0]    irDst;
    logic [4:0]    irSrc1;
    logic [4:0]    irSrc2;
    logic [4:0]    irShamt;
    logic [18:0]   irImm;
    logic [3:0]    irTgt;

    // Loading is only safe while nothing is executing out of the store
    assign memWrEn = progWrEn && ((state == IDLE) || (state == HALT));

    prog_mem #(
        .DEPTH(PROG_DEPTH),
        .AW   (AW)
    ) uProgMem (
        .clk   (clk),
        .wrEn  (memWrEn),
        .wrAddr(progAddr),
        .wrData(progData),
        .rdAddr(pc),
        .rdData(fetchWord)
    );

    assign fetchClass = fetchWord[CLS_HI:CLS_LO];
    assign irClass    = ir[CLS_HI:CLS_LO];
    assign irOpc      = ir[OPC_HI:OPC_LO];
    assign irDst      = ir[DST_HI:DST_LO];
    assign irSrc1     = ir[SRC1_HI:SRC1_LO];
    assign irSrc2     = ir[SRC2_HI:SRC2_LO];
    assign irShamt    = ir[SHAMT_HI:SHAMT_LO];
    assign irImm      = ir[IMM_HI:IMM_LO];
    assign irTgt      = ir[TGT_HI:TGT_LO];

    // Sequencer state, program counter, instruction register and sticky illegal flag
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            pc      <= '0;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            ir      <= irNext;
            illegal <= illegalNext;
        end
    end

    // Next-state logic and datapath controls; outputs depend only on registered state so reset clears them at once
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        irNext      = ir;
        illegalNext = illegal;
        wrEnable    = 1'b0;
        wrReg       = '0;
        rdReg1      = '0;
        rdReg2      = '0;
        opCode      = '0;
        shiftAmt    = '0;
        selCh       = 1'b0;
        selData     = '0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE, HALT: begin
                done = (state == HALT);
                if (start) begin
                    stateNext   = FETCH;
                    pcNext      = '0;
                    illegalNext = 1'b0;
                end
            end

            FETCH: begin
                busy   = 1'b1;
                irNext = fetchWord;
                case (fetchClass)
                    CLS_ALU, CLS_BRZ: stateNext = EXEC;
                    CLS_LOADI:        stateNext = WB;
                    CLS_HALT:         stateNext = HALT;
                    default: begin
                        stateNext   = HALT;
                        illegalNext = 1'b1;
                    end
                endcase
            end

            EXEC: begin
                busy = 1'b1;
                if (irClass == CLS_BRZ) begin
                    rdReg1    = irSrc1;
                    rdReg2    = irSrc1;
                    opCode    = OP_OR;
                    pcNext    = (aluResult == 32'sd0) ? AW'(irTgt) : pc + AW'(1);
                    stateNext = FETCH;
                end else begin
                    rdReg1    = irSrc1;
                    rdReg2    = irSrc2;
                    opCode    = irOpc;
                    shiftAmt  = irShamt;
                    stateNext = WB;
                end
            end

            WB: begin
                busy      = 1'b1;
                wrEnable  = 1'b1;
                wrReg     = irDst;
                pcNext    = pc + AW'(1);
                stateNext = FETCH;
                if (irClass == CLS_LOADI) begin
                    selCh   = 1'b0;
                    selData = signExtImm(irImm);
                end else begin
                    selCh    = 1'b1;
                    rdReg1   = irSrc1;
                    rdReg2   = irSrc2;
                    opCode   = irOpc;
                    shiftAmt = irShamt;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

endmodule
